// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: host-side run controller that sits in front of the pipelined CPU.
//
// A start request captures an argument, holds the CPU in reset for CLR_CYCLES,
// then runs the CPU. The run finishes once ANS0 and ANS1 have stayed unchanged
// for STABLE_CYCLES consecutive RUN cycles. At that point the answers and the
// RUN-cycle count are latched for the host.
//
// Optional feature macro: RUN_TIMEOUT_EN. When it is defined, a run that reaches
// MAX_CYCLES without settling is closed out with timeout_o=1.
//
// Ports:
//   clk_i, rst_ni       clock; asynchronous active-low reset
//   start_i, abort_i    host start (IDLE/DONE only) and abort (CLEAR/RUN only)
//   arg_i               argument for the CPU number input, captured on an accepted start
//   busy_o, done_o      status: busy in CLEAR/RUN, done in DONE
//   timeout_o           the last run ended on the cycle limit
//   result0_o/1_o       latched ANS0/ANS1
//   run_cycles_o        RUN cycles of the last completed run
//   cpu_rst_o           CPU reset, active-low
//   cpu_en_o            CPU enable
//   cpu_number_o        CPU number input
//   cpu_ans0_i/1_i      CPU answers
module cpu_run_ctrl #(
   parameter int unsigned STABLE_CYCLES = 8,
   parameter int unsigned CLR_CYCLES    = 2,
   parameter int unsigned MAX_CYCLES    = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [31:0] arg_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        timeout_o,
   output logic [31:0] result0_o,
   output logic [31:0] result1_o,
   output logic [31:0] run_cycles_o,
   output logic        cpu_rst_o,
   output logic        cpu_en_o,
   output logic [31:0] cpu_number_o,
   input  logic [31:0] cpu_ans0_i,
   input  logic [31:0] cpu_ans1_i
);

   localparam int unsigned ClrW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam int unsigned StW  = $clog2(STABLE_CYCLES + 1);
   localparam logic [ClrW-1:0] ClrLast   = ClrW'(CLR_CYCLES - 1);
   localparam logic [StW-1:0]  StableTgt = StW'(STABLE_CYCLES);
   localparam logic [31:0]     MaxCyc    = 32'(MAX_CYCLES);

   // Elaboration-time sanity checks on the configuration.
   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("STABLE_CYCLES must be at least 1");
   end
   if (CLR_CYCLES < 1) begin : g_bad_clr
      $error("CLR_CYCLES must be at least 1");
   end
   if (MaxCyc == 32'd0) begin : g_bad_max
      $error("MAX_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
   logic [StW-1:0]  stable_q, stable_d;
   logic [31:0]     cyc_q, cyc_d;
   logic [31:0]     prev0_q, prev0_d, prev1_q, prev1_d;
   logic [31:0]     result0_q, result0_d, result1_q, result1_d;
   logic [31:0]     run_cycles_q, run_cycles_d;
   logic [31:0]     number_q, number_d;
`ifdef RUN_TIMEOUT_EN
   logic            timeout_q, timeout_d;
`endif

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      stable_d     = stable_q;
      cyc_d        = cyc_q;
      prev0_d      = prev0_q;
      prev1_d      = prev1_q;
      result0_d    = result0_q;
      result1_d    = result1_q;
      run_cycles_d = run_cycles_q;
      number_d     = number_q;
`ifdef RUN_TIMEOUT_EN
      timeout_d    = timeout_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               number_d  = arg_i;
               cyc_d     = '0;
               stable_d  = '0;
               clr_cnt_d = '0;
`ifdef RUN_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               state_d   = StClear;
            end
         end
         StClear: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (clr_cnt_q == ClrLast) begin
               clr_cnt_d = '0;
               state_d   = StRun;
            end else begin
               clr_cnt_d = clr_cnt_q + ClrW'(1);
            end
         end
         StRun: begin
            if (abort_i) begin
               state_d = StIdle;
            end else begin
               cyc_d   = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
               prev0_d = cpu_ans0_i;
               prev1_d = cpu_ans1_i;
               // cyc_q is zero only in the first RUN cycle, when prev is not yet valid.
               if (cyc_q == 32'd0) begin
                  stable_d = '0;
               end else if (cpu_ans0_i == prev0_q && cpu_ans1_i == prev1_q) begin
                  stable_d = stable_q + StW'(1);
               end else begin
                  stable_d = '0;
               end
               if (stable_d == StableTgt) begin
                  result0_d    = cpu_ans0_i;
                  result1_d    = cpu_ans1_i;
                  run_cycles_d = cyc_d;
                  state_d      = StDone;
               end
`ifdef RUN_TIMEOUT_EN
               // Stability takes precedence when both land on the same cycle.
               else if (cyc_d == MaxCyc) begin
                  result0_d    = cpu_ans0_i;
                  result1_d    = cpu_ans1_i;
                  run_cycles_d = MaxCyc;
                  timeout_d    = 1'b1;
                  state_d      = StDone;
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         clr_cnt_q    <= '0;
         stable_q     <= '0;
         cyc_q        <= '0;
         prev0_q      <= '0;
         prev1_q      <= '0;
         result0_q    <= '0;
         result1_q    <= '0;
         run_cycles_q <= '0;
         number_q     <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         stable_q     <= stable_d;
         cyc_q        <= cyc_d;
         prev0_q      <= prev0_d;
         prev1_q      <= prev1_d;
         result0_q    <= result0_d;
         result1_q    <= result1_d;
         run_cycles_q <= run_cycles_d;
         number_q     <= number_d;
      end
   end

`ifdef RUN_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   // Status and CPU controls are decoded straight from the state register.
   assign busy_o       = (state_q == StClear) || (state_q == StRun);
   assign done_o       = (state_q == StDone);
   // CPU leaves reset in RUN and stays out of it in DONE so its state can be inspected.
   assign cpu_rst_o    = (state_q == StRun) || (state_q == StDone);
   assign cpu_en_o     = (state_q == StRun);
   assign cpu_number_o = number_q;
   assign result0_o    = result0_q;
   assign result1_o    = result1_q;
   assign run_cycles_o = run_cycles_q;

endmodule
